// File: rtl/mac_postproc.sv
// mac_postproc: post-processing stage behind the 27-tap convolution MAC.
// Queues MAC results, then applies bias, rounding, shift, activation and int8 saturation.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, mac_in      MAC done pulse and 24-bit unsigned result
//   bias, shift, act_mode per-result config, sampled with the pulse
//   out_valid, out_ready  valid/ready handshake towards the feature-map writer
//   out_data, out_sat     signed int8 result and "was clipped" flag
//   fifo_count, busy      input queue occupancy, anything queued or in flight
//   overflow, clr_ovf     sticky dropped-pulse flag and its clear
module mac_postproc #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [23:0]              mac_in,
    input  logic [15:0]              bias,
    input  logic [3:0]               shift,
    input  logic [1:0]               act_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_sat,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [23:0] mac;
        logic [15:0] bias;
        logic [3:0]  shift;
        logic [1:0]  mode;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic               s1_valid_q, s1_valid_d;
    logic signed [25:0] s1_r_q, s1_r_d;
    logic [3:0]         s1_shift_q, s1_shift_d;
    logic [1:0]         s1_mode_q, s1_mode_d;

    logic               s2_valid_q, s2_valid_d;
    logic signed [25:0] s2_a_q, s2_a_d;

    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;

    logic               out_adv, s2_en, s1_en;
    logic               pop, push, drop;
    entry_t             head;
    logic signed [25:0] b_sum, r_sum;
    logic [25:0]        rnd;
    logic signed [25:0] s2_shr, s2_act;

    always_comb begin
        // A stage may load when empty or when its contents move on this cycle.
        out_adv = !out_valid_q || out_ready;
        s2_en   = !s2_valid_q || out_adv;
        s1_en   = !s1_valid_q || s2_en;
        pop     = (count_q != '0) && s1_en;
        // A full queue still accepts when the head leaves in the same cycle.
        push    = in_valid && ((count_q != FULL) || pop);
        drop    = in_valid && !push;

        head  = mem_q[rd_ptr_q];
        b_sum = $signed({2'b00, head.mac})
              + $signed({{10{head.bias[15]}}, head.bias});
        rnd   = (head.shift != 4'd0) ? (26'd1 << (head.shift - 4'd1)) : 26'd0;
        r_sum = b_sum + $signed(rnd);

        s2_shr = s1_r_q >>> s1_shift_q;
        case (s1_mode_q)
            2'd1:    s2_act = s2_shr[25] ? 26'sd0 : s2_shr;
            2'd2:    s2_act = s2_shr[25] ? (s2_shr >>> 3) : s2_shr;
            default: s2_act = s2_shr;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        // A drop coinciding with a clear leaves the flag set.
        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        s1_shift_d = s1_shift_q;
        s1_mode_d  = s1_mode_q;
        if (s1_en) begin
            s1_valid_d = pop;
            if (pop) begin
                s1_r_d     = r_sum;
                s1_shift_d = head.shift;
                s1_mode_d  = head.mode;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_a_d     = s2_a_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_a_d = s2_act;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_adv) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                if (s2_a_q > 26'sd127) begin
                    out_data_d = 8'h7F;
                    out_sat_d  = 1'b1;
                end else if (s2_a_q < -26'sd128) begin
                    out_data_d = 8'h80;
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = s2_a_q[7:0];
                    out_sat_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{mac_in, bias, shift, act_mode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_shift_q  <= '0;
            s1_mode_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_a_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            s1_shift_q  <= s1_shift_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_a_q      <= s2_a_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign busy       = (count_q != '0) || s1_valid_q || s2_valid_q || out_valid_q;

endmodule

// File: doc/mac_postproc.md
Name: mac_postproc

Overview:
- Downstream stage of the 27-tap convolution MAC.
- Captures each 24-bit unsigned MAC result on the MAC's done pulse and queues it in a small FIFO.
- Runs each result through a 3-stage pipeline: bias add with rounding, arithmetic right shift, activation (none/ReLU/leaky), then saturation to signed int8.
- Presents results on a valid/ready output towards the feature-map writer.

Parameters:
- DEPTH, 4, input FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle done pulse from the MAC
- mac_in  in  24  unsigned MAC result
- bias  in  16  signed bias
- shift  in  4  right-shift amount, 0..15
- act_mode  in  2  0=none, 1=ReLU, 2=leaky (x1/8), 3=none
- out_valid  out  1  output data valid
- out_ready  in  1  downstream accepts
- out_data  out  8  signed int8 result
- out_sat  out  1  result was clipped
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy
- busy  out  1  FIFO non-empty or any pipeline stage valid
- overflow  out  1  sticky: a pulse was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset clears FIFO pointers/count, all stage valids, out_valid=0, out_data=0, out_sat=0, overflow=0, busy=0.
- Reset mid-operation discards all queued and in-flight results; nothing is emitted afterwards.
- Capture: on each clk edge with in_valid=1, the entry {mac_in, bias, shift, act_mode} is pushed. Config is sampled per entry, so later config changes do not affect queued entries.
- Push is accepted if fifo_count<DEPTH, or if a pop happens in the same cycle.
- Otherwise the pulse is dropped and overflow is set. overflow stays set until a clr_ovf cycle; if a drop and clr_ovf coincide, overflow ends set.
- Pipeline advance: S1, S2 and the output register each load when the stage is empty or the stage itself is advancing.
- The output register advances when out_valid=0 or out_ready=1. Throughput is 1 result/cycle with no bubbles under continuous out_ready.
- FIFO pops into S1 when the FIFO is non-empty and S1 can load.
- Latency: push sampled at edge t0 -> FIFO; S1 at t0+1; S2 at t0+2; out_valid high after edge t0+3 (empty pipe, out_ready=1).
- Handshake: out_valid/out_data/out_sat are held stable while out_valid=1 and out_ready=0. Results leave in capture order.
- S1, bias add: b = zero-extend(mac_in) + sign-extend(bias), 26-bit signed.
- S1, rounding: r = b + (shift!=0 ? 1<<(shift-1) : 0). No overflow is possible in 26 bits.
- S2, shift: s = r >>> shift (arithmetic).
- S2, activation:
  - mode 1: s<0 -> 0.
  - mode 2: s<0 -> s >>> 3 (floor).
  - modes 0/3: unchanged.
- Output stage: saturate to [-128,127]. out_sat=1 iff clipped.
- fifo_count reflects registered occupancy. Simultaneous push and pop leaves the count unchanged.
- Total storage before drop with out_ready=0: DEPTH + 3 (S1, S2, output register).

Test Plan:
- Basic ReLU: mac_in=1000, bias=-200, shift=3, mode=1 -> out_data=100 (0x64), out_sat=0; out_valid rises after edge t0+3.
- Negative paths: mac_in=300, bias=-1000, shift=2.
  - mode=2 -> -22 (0xEA), out_sat=0.
  - mode=1 -> 0.
  - mode=0 -> -128 (0x80), out_sat=1.
- Positive saturation and config isolation: mac_in=50000, bias=0, shift=4, mode=0 -> 127, out_sat=1. Change shift to 0 the cycle after the pulse -> result unchanged.
- Backpressure/overflow, DEPTH=4: out_ready=0, 8 back-to-back pulses with mac_in=1..8, shift=0, mode=0.
  - Required: fifo_count=4, busy=1, overflow=1 (8th dropped).
  - Then out_ready=1 -> exactly outputs 1..7 on consecutive cycles, with out_data held stable while stalled.
- Overflow clear and full-with-pop: clr_ovf pulse -> overflow=0. With FIFO full and out_ready=1, a new pulse is accepted (no overflow) and fifo_count stays 4.
- Reset mid-stream: assert rst_n=0 with 3 entries queued and out_valid=1 -> out_valid=0, fifo_count=0, busy=0 immediately (asynchronous); no output after release.
